// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline segment registers: default widths,
// control-field layout and the per-entry register operation encoding.
package pipe_pkg;

    localparam int unsigned DefDataW = 64;
    localparam int unsigned DefCtrlW = 32;
    localparam int unsigned DefCntW  = 16;

    // Control payload layout as decoded by downstream stages
    localparam int unsigned CtrlRegWriteBit = 0;
    localparam int unsigned CtrlMemWriteBit = 1;
    localparam int unsigned CtrlAluCtrlLsb  = 2;
    localparam int unsigned CtrlAluCtrlW    = 4;
    localparam int unsigned CtrlBrTypeLsb   = 6;
    localparam int unsigned CtrlBrTypeW     = 3;
    localparam int unsigned CtrlCsrTypeLsb  = 9;
    localparam int unsigned CtrlCsrTypeW    = 3;

    typedef enum logic [1:0] {
        EntHold,
        EntLoad,
        EntClear
    } entry_op_e;

endpackage

// File: rtl/seg_entry_reg.sv
// One pipeline entry: valid bit plus control and data payload, with load and
// clear operations. Clear always zeroes control; data only when CLR_DATA is set.
module seg_entry_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned CTRL_W   = DefCtrlW,
    parameter int unsigned CLR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  entry_op_e         op,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            unique case (op)
                EntLoad: begin
                    valid_q <= 1'b1;
                    data_q  <= load_data;
                    ctrl_q  <= load_ctrl;
                end
                EntClear: begin
                    valid_q <= 1'b0;
                    ctrl_q  <= '0;
                    if (CLR_DATA != 0) begin
                        data_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_seg_elastic.sv
// Elastic pipeline segment register with valid/ready handshake, optional skid
// entry, flush with bubble insertion and saturating performance counters.
module pipe_seg_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned CTRL_W   = DefCtrlW,
    parameter int unsigned SKID     = 1,
    parameter int unsigned CLR_DATA = 1,
    parameter int unsigned CNT_W    = DefCntW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              head_valid, skid_valid;
    logic [DATA_W-1:0] head_data, skid_data, head_load_data;
    logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_load_ctrl;
    entry_op_e         head_op, skid_op;
    logic              head_from_skid;
    logic              accept, pop;

    assign accept = in_valid & in_ready & ~stall & ~flush;
    assign pop    = head_valid & out_ready & ~stall & ~flush;

    // Steering: the skid entry only ever fills while the head is held, so FIFO
    // order is kept by always refilling the head from the skid first.
    always_comb begin
        head_op        = EntHold;
        skid_op        = EntHold;
        head_from_skid = 1'b0;
        if (flush) begin
            head_op = EntClear;
            skid_op = EntClear;
        end else if (pop) begin
            if (skid_valid) begin
                head_op        = EntLoad;
                head_from_skid = 1'b1;
                skid_op        = accept ? EntLoad : EntClear;
            end else begin
                head_op = accept ? EntLoad : EntClear;
            end
        end else if (accept) begin
            if (head_valid) begin
                skid_op = EntLoad;
            end else begin
                head_op = EntLoad;
            end
        end
    end

    assign head_load_data = head_from_skid ? skid_data : in_data;
    assign head_load_ctrl = head_from_skid ? skid_ctrl : in_ctrl;

    seg_entry_reg #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .CLR_DATA(CLR_DATA)
    ) u_head (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (head_op),
        .load_data(head_load_data),
        .load_ctrl(head_load_ctrl),
        .valid    (head_valid),
        .data     (head_data),
        .ctrl     (head_ctrl)
    );

    if (SKID != 0) begin : g_skid
        seg_entry_reg #(
            .DATA_W  (DATA_W),
            .CTRL_W  (CTRL_W),
            .CLR_DATA(CLR_DATA)
        ) u_skid (
            .clk      (clk),
            .rst_n    (rst_n),
            .op       (skid_op),
            .load_data(in_data),
            .load_ctrl(in_ctrl),
            .valid    (skid_valid),
            .data     (skid_data),
            .ctrl     (skid_ctrl)
        );
        // Registered ready: no combinational path from out_ready upstream
        assign in_ready = ~skid_valid;
    end else begin : g_no_skid
        logic unused_skid_op;
        assign unused_skid_op = ^skid_op;
        assign skid_valid     = 1'b0;
        assign skid_data      = '0;
        assign skid_ctrl      = '0;
        assign in_ready       = ~stall & (~head_valid | out_ready);
    end

    assign out_valid = head_valid;
    assign out_data  = head_data;
    assign out_ctrl  = head_valid ? head_ctrl : '0;

    logic [2:0]       cnt_evt;
    logic [CNT_W-1:0] cnt_q [3];

    assign cnt_evt = {flush, ~head_valid, head_valid & (~out_ready | stall)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (cnt_evt[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign stall_cnt  = cnt_q[0];
    assign bubble_cnt = cnt_q[1];
    assign flush_cnt  = cnt_q[2];

endmodule

// File: tb/tb_pipe_seg_elastic.sv
// Scoreboard bench for pipe_seg_elastic (SKID=1, CLR_DATA=1, 4-bit counters).
module tb_pipe_seg_elastic;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;
    localparam int unsigned NW = 4;

    typedef logic [DW+CW-1:0] ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic [NW-1:0] stall_cnt, bubble_cnt, flush_cnt;

    ent_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipe_seg_elastic #(
        .DATA_W  (DW),
        .CTRL_W  (CW),
        .SKID    (1),
        .CLR_DATA(1),
        .CNT_W   (NW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall     (stall),
        .flush     (flush),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
        .flush_cnt (flush_cnt)
    );

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    // One clock: scoreboard work at the falling edge, then return just after the rising edge.
    task automatic cycle();
        ent_t e;
        @(negedge clk);
        if (!out_valid) begin
            n_cmp++;
            if (out_ctrl !== '0) begin
                n_err++;
                $display("FAIL bubble_ctrl: got %h want 0", out_ctrl);
            end
        end
        if (!rst_n || flush) begin
            exp_q.delete();
        end else if (!stall) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_extra: got %h/%h want nothing", out_data, out_ctrl);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_data, out_ctrl} !== e) begin
                        n_err++;
                        $display("FAIL sb_order: got %h want %h", {out_data, out_ctrl}, e);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back({in_data, in_ctrl});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0);
        #12;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL rst_data: got %h want 0", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        n_cmp++; if (bubble_cnt !== '0) begin n_err++; $display("FAIL rst_bubble: got %0d want 0", bubble_cnt); end
        // Fill head and skid, then reset asynchronously mid-cycle
        drive(1'b1, 16'h00A1, 8'h11);
        cycle();
        drive(1'b1, 16'h00B2, 8'h22);
        cycle();
        drive(1'b0, '0, '0);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_ctrl !== '0) begin n_err++; $display("FAIL mid_rst_ctrl: got %h want 0", out_ctrl); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL mid_rst_data: got %h want 0", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
        n_cmp++; if ({stall_cnt, bubble_cnt, flush_cnt} !== '0) begin
            n_err++;
            $display("FAIL mid_rst_cnt: got %0d/%0d/%0d want 0/0/0", stall_cnt, bubble_cnt, flush_cnt);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DW'(i), CW'(8'h40 + i));
            cycle();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== DW'(i) || out_ctrl !== CW'(8'h40 + i)) begin
                n_err++;
                $display("FAIL b2b_out: got v=%b %h/%h want v=1 %h/%h", out_valid, out_data, out_ctrl,
                         DW'(i), CW'(8'h40 + i));
            end
        end
        drive(1'b0, '0, '0);
        cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
        n_cmp++; if (stall_cnt !== '0) begin n_err++; $display("FAIL b2b_stall_cnt: got %0d want 0", stall_cnt); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 16'h000A, 8'h0A);
        cycle();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1: got %b want 1", in_ready); end
        drive(1'b1, 16'h000B, 8'h0B);
        cycle();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready2: got %b want 0", in_ready); end
        drive(1'b1, 16'h000C, 8'h0C);
        cycle();
        cycle();
        n_cmp++; if (in_ready !== 1'b0 || out_data !== 16'h000A) begin
            n_err++;
            $display("FAIL bp_hold: got rdy=%b %h want rdy=0 000a", in_ready, out_data);
        end
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        cycle();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h000B || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_second: got v=%b %h rdy=%b want v=1 000b rdy=1", out_valid, out_data, in_ready);
        end
        cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", out_valid); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_flush_stall();
        do_reset();
        drive(1'b1, 16'h1111, 8'h5A);
        cycle();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fl_load: got %b want 1", out_valid); end
        drive(1'b1, 16'hCCCC, 8'hCC);
        stall = 1'b1;
        flush = 1'b1;
        cycle();
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, '0, '0);
        n_cmp++; if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin
            n_err++;
            $display("FAIL fl_kill: got v=%b %h/%h want v=0 0/0", out_valid, out_data, out_ctrl);
        end
        n_cmp++; if (flush_cnt !== NW'(1)) begin n_err++; $display("FAIL fl_cnt: got %0d want 1", flush_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_ghost: got %b want 0", out_valid); end
        end
        n_cmp++; if (flush_cnt !== NW'(1)) begin n_err++; $display("FAIL fl_cnt_hold: got %0d want 1", flush_cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b1, 16'h2222, 8'h33);
        cycle();
        stall     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 16'hDDDD, 8'hDD);
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 16'h2222) begin
                n_err++;
                $display("FAIL st_hold: got v=%b %h want v=1 2222", out_valid, out_data);
            end
        end
        n_cmp++; if (stall_cnt !== NW'(5)) begin n_err++; $display("FAIL st_cnt: got %0d want 5", stall_cnt); end
        stall = 1'b0;
        drive(1'b0, '0, '0);
        cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL st_noaccept: got %b want 0", out_valid); end
        n_cmp++; if (stall_cnt !== NW'(5)) begin n_err++; $display("FAIL st_cnt_end: got %0d want 5", stall_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (14) cycle();
        n_cmp++; if (bubble_cnt !== NW'(14)) begin n_err++; $display("FAIL sat_14: got %0d want 14", bubble_cnt); end
        repeat (6) cycle();
        n_cmp++; if (bubble_cnt !== NW'(15)) begin n_err++; $display("FAIL sat_20: got %0d want 15", bubble_cnt); end
        repeat (5) cycle();
        n_cmp++; if (bubble_cnt !== NW'(15)) begin n_err++; $display("FAIL sat_hold: got %0d want 15", bubble_cnt); end
        n_cmp++; if (stall_cnt !== '0) begin n_err++; $display("FAIL sat_stall: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_random();
        int budget;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            n_cmp++;
            if (in_ready !== (exp_q.size() < 2) || out_valid !== (exp_q.size() != 0)) begin
                n_err++;
                $display("FAIL rnd_occ: got rdy=%b v=%b want occupancy %0d", in_ready, out_valid,
                         exp_q.size());
            end
            drive(1'($urandom_range(0, 1)), DW'($urandom), CW'($urandom));
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        budget = 10;
        while (exp_q.size() != 0 && budget > 0) begin
            cycle();
            budget--;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rnd_drain_timeout: got %0d left want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_flush_stall();
        test_stall();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
